// File: rtl/bcd_to_binary.sv
// Sequential four-digit BCD-to-binary converter.
// Accepts thousands/hundreds/tens/ones on a start pulse, accumulates one digit
// per cycle (acc*10 + digit) and returns the binary value with a done pulse.
// Any digit above 9 short-circuits to a one-cycle error result (y=0, err=1).
// OUT_W must be at least 14 so that 9999 fits; upper bits are zero-filled.

module bcd_to_binary #(
   parameter int unsigned OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       thousands,
   input  logic [3:0]       hundreds,
   input  logic [3:0]       tens,
   input  logic [3:0]       ones,
   output logic [OUT_W-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned DIG_W = 4;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned N_DIG = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [N_DIG-1:0][DIG_W-1:0]  dig_q, dig_d;
   logic [OUT_W-1:0]             acc_q, acc_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [OUT_W-1:0]             y_d;
   logic                         busy_d, done_d, err_d;

   logic                         bad_digit;
   logic [OUT_W-1:0]             acc_x10;
   logic [OUT_W-1:0]             acc_step;

   // Any incoming digit outside 0..9 marks the request as invalid.
   assign bad_digit = (thousands > 4'd9) | (hundreds > 4'd9) |
                      (tens > 4'd9) | (ones > 4'd9);

   // acc*10 as shift-and-add; the largest intermediate (9999) cannot overflow.
   assign acc_x10  = (acc_q << 3) + (acc_q << 1);
   assign acc_step = acc_x10 + OUT_W'(dig_q[cnt_q]);

   // State and datapath registers; reset discards any partial conversion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dig_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         y       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y       <= y_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

   // Next-state and next-output logic; done is a single-cycle pulse.
   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y;
      busy_d  = busy;
      done_d  = 1'b0;
      err_d   = err;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Index 0 holds thousands so digits are consumed MSD first.
               dig_d   = {ones, tens, hundreds, thousands};
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               state_d = bad_digit ? ERR : CONV;
            end
         end

         CONV: begin
            acc_d = acc_step;
            if (cnt_q == CNT_W'(N_DIG - 1)) begin
               y_d     = acc_step;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ERR: begin
            y_d     = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: expectations are queued when a
// conversion is started and compared when done pulses.

module tb_bcd_to_binary;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [3:0]  thousands, hundreds, tens, ones;
   logic [15:0] y;
   logic        busy, done, err;

   typedef struct {
      logic [15:0] y;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   bcd_to_binary #(.OUT_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .thousands (thousands),
      .hundreds  (hundreds),
      .tens      (tens),
      .ones      (ones),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedge counter used for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   // Single checking point for every comparison
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: every done must match the oldest outstanding request
   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("y", 32'(y), 32'(e.y));
            check("err", 32'(err), 32'(e.err));
            check("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Drive one start pulse at a negedge (DUT known idle) and queue the result
   task automatic send(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
      exp_t e;
      thousands = a; hundreds = b; tens = c; ones = d;
      start = 1'b1;
      if (a > 9 || b > 9 || c > 9 || d > 9) begin
         e.y   = 16'h0000;
         e.err = 1'b1;
         e.cyc = cyc + 2;
      end else begin
         e.y   = 16'(int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d));
         e.err = 1'b0;
         e.cyc = cyc + 5;
      end
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Advance to the negedge where done is visible, bounded
   task automatic wait_done();
      int n = 0;
      while (!done && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   // Split a binary value into BCD digits and run it through the DUT
   task automatic round_trip(input int v);
      logic [3:0] a, b, c, d;
      a = 4'((v / 1000) % 10);
      b = 4'((v / 100) % 10);
      c = 4'((v / 10) % 10);
      d = 4'(v % 10);
      send(a, b, c, d);
      wait_done();
      @(negedge clk);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      int dc;
      int rt_vals[9] = '{55, 0, 9, 10, 99, 100, 999, 1000, 9999};

      reset_n = 1'b1;
      start = 1'b0;
      thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_y", 32'(y), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 0,0,5,5: busy for exactly four cycles, done on the fifth sample
      send(4'd0, 4'd0, 4'd5, 4'd5);
      bc = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         bc += int'(busy);
      end
      check("busy_cycles", 32'(bc), 32'd4);
      check("done_t1", 32'(done), 32'd1);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);

      // 9999 then 0000 started in the done cycle
      send(4'd9, 4'd9, 4'd9, 4'd9);
      wait_done();
      send(4'd0, 4'd0, 4'd0, 4'd0);
      check("busy_b2b", 32'(busy), 32'd1);
      wait_done();
      @(negedge clk);

      // Invalid hundreds digit, then a valid request clears err
      send(4'd1, 4'hA, 4'd3, 4'd4);
      wait_done();
      @(negedge clk);
      check("err_held", 32'(err), 32'd1);
      check("done_after_err", 32'(done), 32'd0);
      send(4'd1, 4'd2, 4'd3, 4'd4);
      check("err_cleared", 32'(err), 32'd0);
      wait_done();
      @(negedge clk);
      send(4'd0, 4'd0, 4'd0, 4'hF);
      wait_done();
      @(negedge clk);

      // Start during CONV is ignored and inputs are latched
      send(4'd4, 4'd3, 4'd2, 4'd1);
      thousands = 4'd9; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      dc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         dc += int'(done);
      end
      check("ignored_start", 32'(dc), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Reset in the middle of a 5,0,0,0 conversion
      send(4'd5, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_y", 32'(y), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         dc += int'(done);
      end
      check("no_done_after_rst", 32'(dc), 32'd0);

      // Round trip through a binary-to-BCD split
      foreach (rt_vals[i]) round_trip(rt_vals[i]);
      for (int i = 0; i < 6; i++) round_trip(int'($urandom_range(0, 9999)));

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
